// File: rtl/scr_base_l3_bk_tp_arb.sv
// ---------------------------------------------------------------------------
// scr_base_l3_bk_tp_arb
//   L3 bank tag-pipe arbiter. Four request sources (replay, snoop, fill,
//   core) compete for the D0 stage of the tag pipe. A source may only enter
//   when its set index does not collide with any valid set already in
//   D0..D3, so that two accesses to the same set never overlap in the pipe.
//   Fixed priority replay > snoop > fill > core.
//
//   Optional macro SCR_L3_TP_ARB_STARVE_EN adds a core anti-starvation
//   counter. Once core has lost STARVE_LIM consecutive eligible cycles it is
//   promoted to top priority.
//
// Ports
//   clk, rst_n      bank clock, async active-low reset
//   req_vld[3:0]    per-source valid ([0] replay .. [3] core)
//   req_set         per-source set index, source i at [i*SET_W +: SET_W]
//   req_pld         per-source payload,   source i at [i*PLD_W +: PLD_W]
//   req_rdy[3:0]    one-hot grant (combinational)
//   tp_stall        holds D0..D3 and blocks all grants
//   tp_d0_*         registered D0 stage (vld/src/set/pld)
//   tp_busy         any valid entry in D0..D3
// ---------------------------------------------------------------------------
module scr_base_l3_bk_tp_arb #(
  parameter int SET_W      = 10,
  parameter int PLD_W      = 64,
  parameter int STARVE_LIM = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req_vld,
  input  logic [4*SET_W-1:0] req_set,
  input  logic [4*PLD_W-1:0] req_pld,
  output logic [3:0]         req_rdy,
  input  logic               tp_stall,
  output logic               tp_d0_vld,
  output logic [1:0]         tp_d0_src,
  output logic [SET_W-1:0]   tp_d0_set,
  output logic [PLD_W-1:0]   tp_d0_pld,
  output logic               tp_busy
);

  // Tracker entry 0 doubles as the D0 register's vld/set.
  logic [3:0]            r_trk_vld;
  logic [3:0][SET_W-1:0] r_trk_set;
  logic [1:0]            r_d0_src;
  logic [PLD_W-1:0]      r_d0_pld;

  logic [3:0]            w_hit;
  logic [3:0]            w_elig;
  logic [3:0]            w_gnt;
  logic                  w_boost;
  logic [1:0]            w_gnt_src;
  logic [SET_W-1:0]      w_gnt_set;
  logic [PLD_W-1:0]      w_gnt_pld;

  // Set collision against every valid tracker stage.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < 4; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (r_trk_vld[d] && (req_set[i*SET_W +: SET_W] == r_trk_set[d]))
          w_hit[i] = 1'b1;
      end
    end
  end

  // rst_n is folded in so req_rdy drops asynchronously with reset.
  assign w_elig = req_vld & ~w_hit & {4{~tp_stall & rst_n}};

`ifdef SCR_L3_TP_ARB_STARVE_EN
  localparam logic [7:0] LIM = 8'(STARVE_LIM);
  logic [7:0] r_starve;

  assign w_boost = (r_starve == LIM) && w_elig[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (!tp_stall) begin
      if (!req_vld[3] || w_gnt[3])
        r_starve <= '0;
      else if (w_elig[3] && (|w_gnt[2:0]) && (r_starve != LIM))
        r_starve <= r_starve + 8'd1;
    end
  end
`else
  assign w_boost = 1'b0;
`endif

  always_comb begin
    w_gnt = '0;
    if (w_boost)        w_gnt = 4'b1000;
    else if (w_elig[0]) w_gnt = 4'b0001;
    else if (w_elig[1]) w_gnt = 4'b0010;
    else if (w_elig[2]) w_gnt = 4'b0100;
    else if (w_elig[3]) w_gnt = 4'b1000;
  end

  // Winner mux; with no grant D0 keeps its old set/src/pld and only vld drops.
  always_comb begin
    w_gnt_src = r_d0_src;
    w_gnt_set = r_trk_set[0];
    w_gnt_pld = r_d0_pld;
    for (int i = 0; i < 4; i++) begin
      if (w_gnt[i]) begin
        w_gnt_src = 2'(i);
        w_gnt_set = req_set[i*SET_W +: SET_W];
        w_gnt_pld = req_pld[i*PLD_W +: PLD_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trk_vld <= '0;
      r_trk_set <= '0;
      r_d0_src  <= '0;
      r_d0_pld  <= '0;
    end else if (!tp_stall) begin
      // D3 falls off the end of the chain.
      r_trk_vld <= {r_trk_vld[2:0], |w_gnt};
      r_trk_set <= {r_trk_set[2:0], w_gnt_set};
      r_d0_src  <= w_gnt_src;
      r_d0_pld  <= w_gnt_pld;
    end
  end

  assign req_rdy   = w_gnt;
  assign tp_d0_vld = r_trk_vld[0];
  assign tp_d0_src = r_d0_src;
  assign tp_d0_set = r_trk_set[0];
  assign tp_d0_pld = r_d0_pld;
  assign tp_busy   = |r_trk_vld;

endmodule
